// File: rtl/duty_adjust_if.sv
// Duty-adjust bus: phase, Data-block handshake, base duty in, duty word out.
// The top-level phase input is named prog because "program" is a reserved
// word in SystemVerilog.
interface duty_adjust_if;
  logic        swiptAlive;
  logic [1:0]  prog;
  logic        read;
  logic        write;
  logic        data;
  logic [11:0] l;
  logic [11:0] dutyCycle;

  // Controller/Data-block side: drives phase, handshake and base duty
  modport master (
    output swiptAlive, prog, read, write, data, l,
    input  dutyCycle
  );

  // duty_adjust side: consumes the controls, returns the registered duty word
  modport slave (
    input  swiptAlive, prog, read, write, data, l,
    output dutyCycle
  );
endinterface : duty_adjust_if

// File: rtl/duty_adjust.sv
// Duty-cycle word for the SWIPT PWM stage. It clamps the base duty and,
// during the data phase, amplitude-modulates it with the Data block's serial
// bit stream. The only state is the output register.
module duty_adjust #(
  parameter logic [11:0] DUTY_DEFAULT = 12'd200,
  parameter logic [11:0] DUTY_MIN     = 12'd50,
  parameter logic [11:0] DUTY_MAX     = 12'd500,
  parameter int unsigned MOD_SHIFT    = 2
) (
  input  logic         clk,
  input  logic         nrst,
  duty_adjust_if.slave bus
);

  localparam logic [1:0] PHASE_DATA = 2'b11;

  logic [11:0] base_clamped;
  logic [11:0] mod_delta;
  logic [12:0] mod_sum;
  logic [12:0] mod_diff;
  logic [12:0] mod_value;
  logic        mod_active;
  logic [11:0] duty_cycle_d;
  logic [11:0] duty_cycle_q;

  // Clamp the base duty, then derive the modulated candidate and select the next duty word
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    base_clamped = bus.l;
    if (bus.l < DUTY_MIN) begin
      base_clamped = DUTY_MIN;
    end else if (bus.l > DUTY_MAX) begin
      base_clamped = DUTY_MAX;
    end

    mod_delta = base_clamped >> MOD_SHIFT;
    mod_sum   = {1'b0, base_clamped} + {1'b0, mod_delta};
    // delta never exceeds the clamped base, so the difference cannot wrap
    mod_diff  = {1'b0, base_clamped} - {1'b0, mod_delta};
    mod_value = bus.data ? mod_sum : mod_diff;

    // Read has priority over write: a listening Data block needs a steady carrier
    mod_active = (bus.prog == PHASE_DATA) && !bus.read && bus.write;

    duty_cycle_d = base_clamped;
    if (mod_active) begin
      // Bit 12 is unreachable with the default limits; saturate rather than wrap
      // if the clamp range is ever widened.
      duty_cycle_d = mod_value[12] ? 12'hFFF : mod_value[11:0];
    end
  end

  // Output register; a lost heartbeat clears it exactly like reset
  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    if (!nrst || !bus.swiptAlive) begin
      duty_cycle_q <= DUTY_DEFAULT;
    end else begin
      duty_cycle_q <= duty_cycle_d;
    end
  end

  assign bus.dutyCycle = duty_cycle_q;

endmodule : duty_adjust

// File: tb/tb_duty_adjust.sv
// Self-checking bench for duty_adjust: directed scenarios with literal
// expectations, followed by randomized cycles checked against a behavioural
// model of the duty rules.
module tb_duty_adjust;

  logic clk;
  logic nrst;

  int checks;
  int errors;

  duty_adjust_if bus ();

  duty_adjust dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report a mismatch
  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: dutyCycle=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Behavioural model: the duty value the register must hold after one edge
  function automatic int model_duty(input logic rst_n, input logic alive, input logic [1:0] prog,
                                    input logic rd, input logic wr, input logic dat,
                                    input logic [11:0] base);
    int lc;
    int delta;
    if (!rst_n || !alive) return 200;
    lc = int'(base);
    if (lc < 50)  lc = 50;
    if (lc > 500) lc = 500;
    delta = lc / 4;
    if (prog == 2'b11 && !rd && wr) return dat ? lc + delta : lc - delta;
    return lc;
  endfunction

  // Apply the currently driven inputs for one edge, then sample away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic alive, input logic [1:0] prog, input logic rd,
                       input logic wr, input logic dat, input logic [11:0] base);
    bus.swiptAlive = alive;
    bus.prog       = prog;
    bus.read       = rd;
    bus.write      = wr;
    bus.data       = dat;
    bus.l          = base;
  endtask

  initial begin
    logic [11:0] rnd_l;
    int          exp_duty;

    checks = 0;
    errors = 0;
    nrst   = 1'b0;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 12'd300);

    // Reset holds the default regardless of l
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_default", bus.dutyCycle, 12'd200);
    end
    nrst = 1'b1;
    tick();
    check("post_reset_pass", bus.dutyCycle, 12'd300);

    // Pass-through clamp in the frequency-search phase
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 12'd20);
    tick();
    check("clamp_low", bus.dutyCycle, 12'd50);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 12'd600);
    tick();
    check("clamp_high", bus.dutyCycle, 12'd500);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 12'h1F4);
    tick();
    check("clamp_at_max", bus.dutyCycle, 12'd500);
    drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 12'd50);
    tick();
    check("ignore_write_outside_data", bus.dutyCycle, 12'd50);

    // Modulation in the data phase
    drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 12'd200);
    tick();
    check("mod_bit1", bus.dutyCycle, 12'd250);
    bus.data = 1'b0;
    tick();
    check("mod_bit0", bus.dutyCycle, 12'd150);
    bus.data = 1'b1;
    tick();
    check("mod_bit1_again", bus.dutyCycle, 12'd250);
    bus.write = 1'b0;
    tick();
    check("mod_idle", bus.dutyCycle, 12'd200);

    // Read priority, then modulation on clamped bases
    drive(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 12'd200);
    tick();
    check("read_priority", bus.dutyCycle, 12'd200);
    drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 12'd600);
    tick();
    check("mod_clamped_high", bus.dutyCycle, 12'd625);
    drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 12'd20);
    tick();
    check("mod_clamped_low", bus.dutyCycle, 12'd38);

    // Heartbeat loss mid-transmission
    drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 12'd400);
    tick();
    check("hb_before", bus.dutyCycle, 12'd500);
    bus.swiptAlive = 1'b0;
    tick();
    check("hb_lost", bus.dutyCycle, 12'd200);
    bus.swiptAlive = 1'b1;
    tick();
    check("hb_restored", bus.dutyCycle, 12'd500);

    // Leaving the data phase during a write leaves no residual modulation
    drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 12'd200);
    tick();
    check("exit_before", bus.dutyCycle, 12'd150);
    bus.prog = 2'b00;
    tick();
    check("exit_after", bus.dutyCycle, 12'd200);

    // Randomized cycles against the behavioural model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0:       rnd_l = 12'($urandom_range(60));
        1:       rnd_l = 12'($urandom_range(520, 480));
        default: rnd_l = 12'($urandom_range(4095));
      endcase
      nrst = ($urandom_range(31) != 0);
      drive(($urandom_range(15) != 0),
            ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'b11,
            ($urandom_range(3) == 0),
            ($urandom_range(3) != 0),
            1'($urandom_range(1)),
            rnd_l);
      exp_duty = model_duty(nrst, bus.swiptAlive, bus.prog, bus.read, bus.write, bus.data, bus.l);
      tick();
      check("random", bus.dutyCycle, 12'(exp_duty));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_duty_adjust

// File: doc/duty_adjust.md
Name: duty_adjust

Overview:
- Produces the duty-cycle word that drives the SWIPT PWM output stage (SwiptOut `l` input).
- The base duty `l` comes from the top-level power/duty controller.
- During the data phase (program = 2'b11), the Data block can amplitude-modulate the duty with a serial bit stream (`write`/`data`) for downlink signalling, or hold it steady while it listens (`read`).
- Outside the data phase it passes a range-clamped copy of `l`.

Parameters:
- DUTY_DEFAULT, 200 (12'hC8), duty value applied after reset or when SWIPT is not alive.
- DUTY_MIN, 50 (12'h32), lower clamp applied to base duty `l`.
- DUTY_MAX, 500 (12'h1F4), upper clamp applied to base duty `l`.
- MOD_SHIFT, 2, modulation depth; delta = clamped base >> MOD_SHIFT (default 25%).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- nrst  in  1  synchronous active-low reset.
- swiptAlive  in  1  SWIPT heartbeat valid; low acts as a synchronous clear.
- program  in  2  top-level phase: 00 idle, 01 freq search, 10 current measure, 11 data/power.
- read  in  1  Data block is receiving; duty must be held unmodulated.
- write  in  1  Data block is transmitting; `data` carries the current bit.
- data  in  1  serial downlink bit, valid while write=1.
- l  in  12  requested base duty (unsigned, permille of PWM period).
- dutyCycle  out  12  registered duty word to the PWM generator.

Behaviour:
- Reset: nrst is synchronous, active-low; clock is clk. If nrst=0 or swiptAlive=0 at a rising edge, dutyCycle <= DUTY_DEFAULT (200). Clear has priority over everything.
- Base clamp (combinational): lc = DUTY_MIN if l < DUTY_MIN; DUTY_MAX if l > DUTY_MAX; else l.
- Modulation delta: delta = lc >> MOD_SHIFT (integer truncation).
- Sums and differences are computed 13 bits wide. With the defaults, the result range is 38..625, so no over- or underflow can occur.
- Output selection, registered, 1-cycle latency from any input change:
  - program != 2'b11 -> dutyCycle <= lc; read/write/data are ignored.
  - program == 2'b11 and read=1 -> dutyCycle <= lc. Read has priority over a simultaneous write.
  - program == 2'b11, read=0, write=1, data=1 -> dutyCycle <= lc + delta.
  - program == 2'b11, read=0, write=1, data=0 -> dutyCycle <= lc - delta.
  - program == 2'b11, read=0, write=0 -> dutyCycle <= lc.
- Bit timing is owned entirely by the Data block: each cycle with write=1 samples `data` and updates dutyCycle. The block adds no bit-period counter and no bit buffering.
- Leaving the data phase while write=1 returns dutyCycle to lc on the next edge. There is no residual modulation.
- A change of `l` during a write is reflected on the next edge, with delta recomputed from the new lc.
- No internal state other than the dutyCycle register.

Test Plan:
- Reset: nrst=0 for several cycles, l=300 -> dutyCycle=200. After nrst=1 with program=00 -> dutyCycle=300 one cycle later.
- Pass-through clamp: program=01. Apply l=20 -> 50, l=600 -> 500, l=0x1F4 -> 500. Each result appears one cycle after the input.
- Modulation: program=11, l=200, write=1, data toggling 1,0,1 -> dutyCycle 250,150,250, each one cycle after `data`. With write=0 -> 200.
- Priority and clamped modulation: program=11, read=1 with write=1, data=1, l=200 -> 200. Then read=0 with l=600, data=1 -> 625; l=20, data=0 -> 38.
- Heartbeat loss mid-transmission: program=11, write=1, data=1, l=400 (dutyCycle=500). Drop swiptAlive for 1 cycle -> dutyCycle=200 on that edge, then 500 again once swiptAlive=1.
- Phase exit: program switches 11 -> 00 while write=1, data=0, l=200 -> dutyCycle goes 150 -> 200 on the next edge.
